// File: rtl/sirv_gnrl_wbck_arb.sv
// ---------------------------------------------------------------------------
// sirv_gnrl_wbck_arb
//   Write-back arbiter: NUM requesters (ALU, LSU, MulDiv, CSR, ...) share a
//   single register-file write port. One request is accepted per cycle and
//   captured in a single output stage, which drives the bank's load enable,
//   address and data straight from flops.
//
//   Build option:
//     SIRV_WBCK_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index
//                                               wins, no rotating pointer
//                                  undefined -> round-robin (default)
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   req_valid  [NUM]     per-requester write request
//   req_ready  [NUM]     per-requester accept (valid & ready = transfer)
//   req_addr   [NUM*AW]  packed addresses, requester i at [i*AW +: AW]
//   req_data   [NUM*DW]  packed data, requester i at [i*DW +: DW]
//   rf_wen     write request to the register bank
//   rf_waddr   write address
//   rf_wdata   write data
//   rf_ready   bank accepts the write this cycle
//   busy       stage occupied or any request pending
// ---------------------------------------------------------------------------
module sirv_gnrl_wbck_arb #(
    parameter int NUM = 4,
    parameter int DW  = 32,
    parameter int AW  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM-1:0]      req_valid,
    output logic [NUM-1:0]      req_ready,
    input  logic [NUM*AW-1:0]   req_addr,
    input  logic [NUM*DW-1:0]   req_data,
    output logic                rf_wen,
    output logic [AW-1:0]       rf_waddr,
    output logic [DW-1:0]       rf_wdata,
    input  logic                rf_ready,
    output logic                busy
);

    localparam int PW = (NUM > 1) ? $clog2(NUM) : 1;

    // Index wrap for the rotating scan; operands never exceed 2*NUM-2.
    function automatic int wrap(input int a);
        return (a >= NUM) ? (a - NUM) : a;
    endfunction

    logic              r_stg_vld;
    logic [AW-1:0]     r_stg_addr;
    logic [DW-1:0]     r_stg_data;

    logic [PW-1:0]     w_ptr;
    logic [PW-1:0]     w_ptr_nxt;
    logic [NUM-1:0]    w_grant;
    logic [PW-1:0]     w_win;
    logic              w_found;
    logic              w_stage_free;
    logic              w_xfer;
    logic [AW-1:0]     w_sel_addr;
    logic [DW-1:0]     w_sel_data;

`ifdef SIRV_WBCK_ARB_FIXED_PRIO_EN
    // Fixed priority: the scan always starts at index 0.
    assign w_ptr = '0;
`else
    logic [PW-1:0]     r_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_ptr <= '0;
        else if (w_xfer)
            r_ptr <= w_ptr_nxt;
    end

    assign w_ptr = r_ptr;
`endif

    // First valid bit scanning from w_ptr upward, wrapping. Depends only on
    // req_valid and the pointer, never on address or data.
    always_comb begin
        w_grant = '0;
        w_win   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM; k++) begin
            if (!w_found && req_valid[wrap(int'(w_ptr) + k)]) begin
                w_found                          = 1'b1;
                w_grant[wrap(int'(w_ptr) + k)]   = 1'b1;
                w_win                            = PW'(wrap(int'(w_ptr) + k));
            end
        end
    end

    assign w_ptr_nxt    = (w_win == PW'(NUM - 1)) ? '0 : w_win + 1'b1;

    // Stage can take a new entry when empty or being drained this cycle.
    assign w_stage_free = !r_stg_vld || rf_ready;
    assign req_ready    = w_stage_free ? w_grant : '0;
    assign w_xfer       = |req_ready;

    // Grant is one-hot, so an OR-mux selects the winner's payload.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = w_sel_addr | req_addr[i*AW +: AW];
                w_sel_data = w_sel_data | req_data[i*DW +: DW];
            end
        end
    end

    // Output stage: reload on transfer (covers back-to-back drain+load),
    // clear valid on a bare drain; address/data hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stg_vld  <= 1'b0;
            r_stg_addr <= '0;
            r_stg_data <= '0;
        end else if (w_xfer) begin
            r_stg_vld  <= 1'b1;
            r_stg_addr <= w_sel_addr;
            r_stg_data <= w_sel_data;
        end else if (r_stg_vld && rf_ready) begin
            r_stg_vld  <= 1'b0;
        end
    end

    assign rf_wen   = r_stg_vld;
    assign rf_waddr = r_stg_addr;
    assign rf_wdata = r_stg_data;
    assign busy     = r_stg_vld || (|req_valid);

endmodule

// File: tb/tb_sirv_gnrl_wbck_arb.sv
// ---------------------------------------------------------------------------
// tb_sirv_gnrl_wbck_arb
//   Self-checking bench for sirv_gnrl_wbck_arb. A behavioural model keeps the
//   stage contents, the priority index and the set of pending requesters;
//   each cycle the expected accept vector and bank outputs are derived from
//   the arbitration rules and compared with the DUT.
// ---------------------------------------------------------------------------
module tb_sirv_gnrl_wbck_arb;

    localparam int NUM = 4;
    localparam int DW  = 32;
    localparam int AW  = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NUM-1:0]      req_valid;
    logic [NUM-1:0]      req_ready;
    logic [NUM*AW-1:0]   req_addr;
    logic [NUM*DW-1:0]   req_data;
    logic                rf_wen;
    logic [AW-1:0]       rf_waddr;
    logic [DW-1:0]       rf_wdata;
    logic                rf_ready;
    logic                busy;

    always #5 clk = ~clk;

    sirv_gnrl_wbck_arb #(.NUM(NUM), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_ready  (rf_ready),
        .busy      (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Requester side: pending flag plus held address/data.
    logic [NUM-1:0] pv;
    logic [AW-1:0]  pa [NUM];
    logic [DW-1:0]  pd [NUM];

    // Model state.
    bit             m_vld;
    logic [AW-1:0]  m_addr;
    logic [DW-1:0]  m_data;
    int             m_ptr;
    int             m_acc;     // index accepted in the last step, -1 if none

    // Observed values from the last step.
    logic [NUM-1:0] o_rdy;
    logic           o_wen;
    logic [AW-1:0]  o_waddr;
    logic [DW-1:0]  o_wdata;
    logic           o_busy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, then advance the model.
    task automatic step(input bit rst, input bit rdy);
        int             win;
        logic [NUM-1:0] exp_rdy;
        @(negedge clk);
        rst_n     = rst;
        rf_ready  = rdy;
        req_valid = pv;
        for (int i = 0; i < NUM; i++) begin
            req_addr[i*AW +: AW] = pa[i];
            req_data[i*DW +: DW] = pd[i];
        end
        #1;
        win = -1;
        for (int k = 0; k < NUM; k++) begin
`ifdef SIRV_WBCK_ARB_FIXED_PRIO_EN
            if (win < 0 && pv[k]) win = k;
`else
            if (win < 0 && pv[(m_ptr + k) % NUM]) win = (m_ptr + k) % NUM;
`endif
        end
        exp_rdy = '0;
        if (win >= 0 && (!m_vld || rdy)) exp_rdy[win] = 1'b1;

        o_rdy = req_ready; o_wen = rf_wen; o_waddr = rf_waddr;
        o_wdata = rf_wdata; o_busy = busy;
        chk("req_ready", req_ready, exp_rdy);
        chk("rf_wen",    rf_wen,    m_vld);
        chk("rf_waddr",  rf_waddr,  m_addr);
        chk("rf_wdata",  rf_wdata,  m_data);
        chk("busy",      busy,      m_vld || (|pv));

        @(posedge clk);
        m_acc = -1;
        if (!rst) begin
            m_vld = 0; m_addr = '0; m_data = '0; m_ptr = 0;
        end else if (exp_rdy != '0) begin
            m_acc  = win;
            m_vld  = 1;
            m_addr = pa[win];
            m_data = pd[win];
            m_ptr  = (win + 1) % NUM;
            pv[win] = 1'b0;
        end else if (m_vld && rdy) begin
            m_vld = 0;
        end
    endtask

    task automatic arm(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pv[i] = 1'b1; pa[i] = a; pd[i] = d;
    endtask

    int         rr_exp [5];
    logic [AW-1:0] hold_a;
    logic [DW-1:0] hold_d;

    initial begin
        rst_n = 1'b0; rf_ready = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        pv = '0;
        for (int i = 0; i < NUM; i++) begin pa[i] = '0; pd[i] = '0; end
        m_vld = 0; m_addr = '0; m_data = '0; m_ptr = 0; m_acc = -1;

        // Reset: model starts empty; first reset cycle leaves outputs unknown
        // until the edge, so only the cycle after is compared.
        @(posedge clk);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        chk("rst_wen", o_wen, 1'b0);
        chk("rst_rdy", o_rdy, '0);

        // Single request from requester 2.
        arm(2, 5'd3, 32'hA5A5_0001);
        step(1'b1, 1'b1);
        chk("single_rdy", o_rdy, 4'b0100);
        step(1'b1, 1'b0);
        chk("single_wen",   o_wen,   1'b1);
        chk("single_waddr", o_waddr, 5'd3);
        chk("single_wdata", o_wdata, 32'hA5A5_0001);
        // Drain with nothing pending.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("drain_wen",  o_wen,  1'b0);
        chk("drain_busy", o_busy, 1'b0);

        // All four held valid from reset.
        step(1'b0, 1'b1);
`ifdef SIRV_WBCK_ARB_FIXED_PRIO_EN
        rr_exp = '{0, 0, 0, 0, 0};
`else
        rr_exp = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < NUM; i++) arm(i, AW'(i + 8), 32'hC0DE_0000 + DW'(i));
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b1);
            chk("rr_order", m_acc, rr_exp[c]);
            if (c > 0) chk("rr_wen", o_wen, 1'b1);
            if (m_acc >= 0) arm(m_acc, AW'(c + 16), 32'hBEEF_0000 + DW'(c));
        end

        // Backpressure: fill stage from requester 3 (ptr wraps to 0), then
        // hold rf_ready low with 0 and 1 pending.
        step(1'b0, 1'b1);
        pv = '0;
        arm(3, 5'd21, 32'h1234_5678);
        step(1'b1, 1'b1);
        arm(0, 5'd1, 32'h0000_00AA);
        arm(1, 5'd2, 32'h0000_00BB);
        hold_a = 5'd21; hold_d = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 1'b0);
            chk("bp_rdy",   o_rdy,   '0);
            chk("bp_waddr", o_waddr, hold_a);
            chk("bp_wdata", o_wdata, hold_d);
        end
        step(1'b1, 1'b1);
        chk("bp_release_rdy", o_rdy, 4'b0001);
        chk("bp_release_wen", o_wen, 1'b1);

        // Reset mid-write after requester 2 won.
        pv = '0;
        arm(2, 5'd7, 32'hDEAD_0002);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("mid_wen_before", o_wen, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        chk("mid_wen",   o_wen,   1'b0);
        chk("mid_waddr", o_waddr, '0);
        chk("mid_wdata", o_wdata, '0);
        chk("mid_rdy",   o_rdy,   '0);
        arm(0, 5'd9, 32'h0000_0009);
        arm(2, 5'd10, 32'h0000_000A);
        step(1'b1, 1'b1);
        chk("mid_first_win", m_acc, 0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM; i++)
                if (!pv[i] && ($urandom % 3 == 0))
                    arm(i, AW'($urandom), DW'($urandom));
            step(($urandom % 60) != 0, ($urandom % 4) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/sirv_gnrl_wbck_arb.md
# sirv_gnrl_wbck_arb

Write-back arbiter that shares one register-file write port among NUM requesters (ALU, LSU, MulDiv, CSR and similar). Each request is a valid/ready handshake that carries a destination address and data. The arbiter picks one request per cycle, round-robin by default, and captures it in a single output stage. That stage drives the load-enable, address and data of the register bank built from load-enable flops. Writes reach the bank one cycle after acceptance and are held stable until the bank accepts them.

## Interface
Parameters:
- NUM, 4, number of requesters (2..8)
- DW, 32, write data width
- AW, 5, register address width

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- req_valid  input  NUM  per-requester write request
- req_ready  output  NUM  per-requester accept; transfer when valid & ready
- req_addr  input  NUM*AW  packed destination addresses, requester i at [i*AW +: AW]
- req_data  input  NUM*DW  packed write data, requester i at [i*DW +: DW]
- rf_wen  output  1  write request to the register bank (drives its load enable)
- rf_waddr  output  AW  write address
- rf_wdata  output  DW  write data
- rf_ready  input  1  bank accepts the write this cycle; write completes when rf_wen & rf_ready
- busy  output  1  high when rf_wen is high or any req_valid bit is high

## Operation
- State:
  - output stage: stg_vld, stg_addr, stg_data
  - round-robin pointer ptr, log2(NUM) bits, marking the highest-priority index
- stage_free = !stg_vld | rf_ready.
- Arbitration:
  - Combinational, evaluated only over req_valid.
  - Winner is the first set bit scanning ptr, ptr+1, …, wrapping modulo NUM.
  - grant is one-hot, or zero when no request is valid.
- req_ready[i] = grant[i] & stage_free. At most one req_ready bit is high per cycle.
- On a transfer by requester i:
  - stg_vld <= 1
  - stg_addr/stg_data <= requester i's addr/data
  - ptr <= (i+1) mod NUM
- On stage drain (stg_vld & rf_ready) with no new transfer: stg_vld <= 0. Address and data hold their last values.
- Simultaneous drain and transfer: the stage reloads the new request, and stg_vld stays 1 (back-to-back writes).
- ptr is unchanged in any cycle without a transfer.
- Requesters hold valid, addr and data until accepted. The arbiter does not latch losing requests.
- Outputs: rf_wen = stg_vld, rf_waddr = stg_addr, rf_wdata = stg_data.
- While rf_wen=1 and rf_ready=0, rf_waddr and rf_wdata must not change.
- Reset values:
  - ptr=0, stg_vld=0, stg_addr=0, stg_data=0
  - hence rf_wen=0, rf_waddr=0, rf_wdata=0, req_ready=0
- Reset mid-operation: a pending stage write is discarded without reaching the bank, and ptr returns to 0.

## Timing
- Latency: request accepted in cycle N → rf_wen=1 in cycle N+1.
- Throughput: one write per cycle while rf_ready is held 1.
- req_ready is combinational from req_valid and rf_ready. It is never derived from req_addr or req_data.
- rf_wen, rf_waddr and rf_wdata come straight from flops, with no combinational path from the inputs.
- When rf_ready=0 and stg_vld=1, all req_ready bits are 0.

## Configuration
- SIRV_WBCK_ARB_FIXED_PRIO_EN defined:
  - fixed priority, lowest index wins
  - ptr is not implemented and is treated as constant 0
  - latency and handshake unchanged
- Macro undefined: round-robin as described above.

## Test plan
- Reset, then a single request: req_valid=4'b0100, addr=3, data=32'hA5A5_0001, rf_ready=1 → req_ready=4'b0100 in the same cycle; next cycle rf_wen=1, rf_waddr=3, rf_wdata=32'hA5A5_0001; ptr=3.
- All four requesters held valid with rf_ready=1 from reset → grants in order 0,1,2,3,0, one per cycle; rf_wen stays 1 throughout. With FIXED_PRIO_EN, requester 0 wins every cycle.
- Backpressure: rf_ready=0 for 3 cycles while the stage is full and req_valid=4'b0011 → req_ready=0 for all 3 cycles, rf_waddr/rf_wdata unchanged. rf_ready=1 in cycle 4 → the bank write completes and requester 0 is accepted in the same cycle.
- Drain without a new request: stage full, req_valid=0, rf_ready=1 → rf_wen=0 next cycle; busy=0.
- rst_n=0 for one cycle while stg_vld=1 and rf_ready=0 → next cycle rf_wen=0, rf_waddr=0, rf_wdata=0, req_ready=0; the first request after reset comes from index 0 even if the previous winner was index 2.
